btb_predictor: RTL and testbench

- Branch target buffer feeding the next-PC generator in IF.
- Combinationally looks up the current fetch PC (PCF) and returns a taken/not-taken prediction plus predicted target.
- Trains from the resolved conditional branch in EX using a direct-mapped table with 2-bit saturating counters.
- Keeps branch and mispredict performance counters.

---
 rtl/btb_predictor.sv | 108 ++++++++++
 tb/tb_btb_predictor.sv | 129 ++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - direct-mapped branch target buffer with 2-bit counters
// Zero-latency lookup on PCF, training from the resolved EX branch, perf counters.
module btb_predictor #(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  input  logic [31:0] PCE,
  input  logic        IsBranchE,
  input  logic        BranchE,
  input  logic [31:0] BranchTarget,
  input  logic        BranchPredictedE,
  input  logic        StallE,
  output logic        BranchPredictedF,
  output logic [31:0] BranchPredictedTargetF,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredCount
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];
  logic [1:0]         cnt_d    [ENTRIES];
  logic [31:0]        branch_count_q, branch_count_d;
  logic [31:0]        mispred_count_q, mispred_count_d;

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e, upd;
  logic             unused_pc_lsbs;

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[31:IDX_W+2];
  assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

  assign hit_f = valid_q[idx_f] & (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] & (tag_q[idx_e] == tag_e);
  // A stalled branch trains only on the cycle it finally leaves EX.
  assign upd   = IsBranchE & ~StallE;

  // Lookup reads registered state only, so same-cycle updates are not bypassed.
  assign BranchPredictedF       = hit_f & cnt_q[idx_f][1];
  assign BranchPredictedTargetF = BranchPredictedF ? target_q[idx_f] : 32'h0;
  assign BranchCount            = branch_count_q;
  assign MispredCount           = mispred_count_q;

  always_comb begin
    valid_d         = valid_q;
    tag_d           = tag_q;
    target_d        = target_q;
    cnt_d           = cnt_q;
    branch_count_d  = branch_count_q;
    mispred_count_d = mispred_count_q;
    if (upd) begin
      branch_count_d = branch_count_q + 32'd1;
      if (BranchE != BranchPredictedE) begin
        mispred_count_d = mispred_count_q + 32'd1;
      end
      if (hit_e) begin
        if (BranchE) begin
          if (cnt_q[idx_e] != 2'b11) begin
            cnt_d[idx_e] = cnt_q[idx_e] + 2'b01;
          end
          target_d[idx_e] = BranchTarget;
        end else if (cnt_q[idx_e] != 2'b00) begin
          cnt_d[idx_e] = cnt_q[idx_e] - 2'b01;
        end
      end else if (BranchE) begin
        valid_d[idx_e]  = 1'b1;
        tag_d[idx_e]    = tag_e;
        target_d[idx_e] = BranchTarget;
        cnt_d[idx_e]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q         <= '0;
      branch_count_q  <= 32'd0;
      mispred_count_q <= 32'd0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= 2'b00;
      end
    end else begin
      valid_q         <= valid_d;
      cnt_q           <= cnt_d;
      branch_count_q  <= branch_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  // Tag and target are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - scoreboard bench for btb_predictor
// Stimulus queues expected lookup/counter values; a negedge monitor pops and compares.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF, PCE, BranchTarget;
  logic        IsBranchE, BranchE, BranchPredictedE, StallE;
  logic        BranchPredictedF;
  logic [31:0] BranchPredictedTargetF, BranchCount, MispredCount;

  typedef struct {
    string       name;
    logic        pred;
    logic [31:0] tgt;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  logic chk_req = 1'b0;
  int   checks = 0;
  int   failures = 0;

  btb_predictor #(.ENTRIES(64)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PCE(PCE), .IsBranchE(IsBranchE),
    .BranchE(BranchE), .BranchTarget(BranchTarget),
    .BranchPredictedE(BranchPredictedE), .StallE(StallE),
    .BranchPredictedF(BranchPredictedF),
    .BranchPredictedTargetF(BranchPredictedTargetF),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=0x%08h expected=0x%08h", name, field, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_req) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow actual=empty expected=entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp(e.name, "pred", {31'd0, BranchPredictedF}, {31'd0, e.pred});
        cmp(e.name, "tgt", BranchPredictedTargetF, e.tgt);
        cmp(e.name, "bcnt", BranchCount, e.bc);
        cmp(e.name, "mcnt", MispredCount, e.mc);
      end
    end
  end

  // Drive one cycle; expectations describe outputs before this cycle's edge.
  task automatic step(input string name, input logic r, input logic [31:0] pcf,
                      input logic isb, input logic [31:0] pce, input logic br,
                      input logic [31:0] tgt, input logic bpe, input logic stall,
                      input logic e_pred, input logic [31:0] e_tgt,
                      input logic [31:0] e_bc, input logic [31:0] e_mc);
    exp_t e;
    rst = r; PCF = pcf; IsBranchE = isb; PCE = pce; BranchE = br;
    BranchTarget = tgt; BranchPredictedE = bpe; StallE = stall;
    e.name = name; e.pred = e_pred; e.tgt = e_tgt; e.bc = e_bc; e.mc = e_mc;
    exp_q.push_back(e);
    chk_req = 1'b1;
    @(posedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; PCF = 32'h0; PCE = 32'h0; IsBranchE = 1'b0; BranchE = 1'b0;
    BranchTarget = 32'h0; BranchPredictedE = 1'b0; StallE = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    //     name        rst pcf       isb pce       br  tgt      bpe st  pred tgt      bc  mc
    step("post_reset",  0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0,  0, 32'h0,   0, 0);
    step("alloc",       0, 32'h100, 1, 32'h100, 1, 32'h40,  0, 0,  0, 32'h0,   0, 0);
    step("nt1",         0, 32'h100, 1, 32'h100, 0, 32'h0,   1, 0,  1, 32'h40,  1, 1);
    step("nt2",         0, 32'h100, 1, 32'h100, 0, 32'h0,   0, 0,  0, 32'h0,   2, 2);
    step("nt3",         0, 32'h100, 1, 32'h100, 0, 32'h0,   0, 0,  0, 32'h0,   3, 2);
    step("t1",          0, 32'h100, 1, 32'h100, 1, 32'h40,  0, 0,  0, 32'h0,   4, 2);
    step("t2",          0, 32'h100, 1, 32'h100, 1, 32'h44,  0, 0,  0, 32'h0,   5, 3);
    step("t3",          0, 32'h100, 1, 32'h100, 1, 32'h40,  1, 0,  1, 32'h44,  6, 4);
    step("t_sat",       0, 32'h100, 1, 32'h100, 1, 32'h40,  1, 0,  1, 32'h40,  7, 4);
    step("nt_from11",   0, 32'h100, 1, 32'h100, 0, 32'h0,   1, 0,  1, 32'h40,  8, 4);
    step("weak_taken",  0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0,  1, 32'h40,  9, 5);
    step("alias_wr",    0, 32'h100, 1, 32'h500, 1, 32'h80,  0, 0,  1, 32'h40,  9, 5);
    step("alias_old",   0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0,  0, 32'h0,  10, 6);
    step("alias_new",   0, 32'h500, 0, 32'h0,   0, 32'h0,   0, 0,  1, 32'h80, 10, 6);
    step("nt_miss",     0, 32'h500, 1, 32'h900, 0, 32'h0,   0, 0,  1, 32'h80, 10, 6);
    step("nt_miss_chk", 0, 32'h500, 0, 32'h0,   0, 32'h0,   0, 0,  1, 32'h80, 11, 6);
    step("same_cycle",  0, 32'h200, 1, 32'h200, 1, 32'h300, 0, 0,  0, 32'h0,  11, 6);
    step("next_cycle",  0, 32'h200, 0, 32'h0,   0, 32'h0,   0, 0,  1, 32'h300,12, 7);
    step("pc_lsbs",     0, 32'h203, 0, 32'h0,   0, 32'h0,   0, 0,  1, 32'h300,12, 7);
    for (int i = 0; i < 3; i++)
      step("stalled",   0, 32'h200, 1, 32'h200, 0, 32'h0,   1, 1,  1, 32'h300,12, 7);
    step("stall_rel",   0, 32'h200, 1, 32'h200, 0, 32'h0,   1, 0,  1, 32'h300,12, 7);
    step("after_stall", 0, 32'h200, 1, 32'h200, 1, 32'h300, 0, 0,  0, 32'h0,  13, 8);
    step("once_only",   0, 32'h200, 0, 32'h0,   0, 32'h0,   0, 0,  1, 32'h300,14, 9);
    step("rst_upd",     1, 32'h200, 1, 32'h200, 1, 32'h300, 0, 0,  1, 32'h300,14, 9);
    step("rst_clear",   0, 32'h200, 0, 32'h0,   1, 32'h0,   0, 0,  0, 32'h0,   0, 0);
    step("bubble",      0, 32'h100, 0, 32'h100, 1, 32'h40,  0, 0,  0, 32'h0,   0, 0);
    step("bubble_chk",  0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 0,  0, 32'h0,   0, 0);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
